// File: rtl/mfe_window_sched_if.sv
// mfe_window_sched_if: window/median handshake between the window sequencer
// (master) and the median sorter (slave).
//   win_valid/win_ready/win_data : 3x3 window transfer, sequencer -> sorter
//   med_valid/med_data           : median result strobe, sorter -> sequencer
interface mfe_window_sched_if;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic        med_valid;
    logic [7:0]  med_data;

    modport master (
        output win_valid,
        output win_data,
        input  win_ready,
        input  med_valid,
        input  med_data
    );

    modport slave (
        input  win_valid,
        input  win_data,
        output win_ready,
        output med_valid,
        output med_data
    );
endinterface

// File: rtl/mfe_window_sched.sv
// mfe_window_sched: raster-order 3x3 window sequencer for the median-filter
// engine. It fetches neighbourhoods from the input ROM, reuses the two previous
// window columns when stepping right, hands each window to the sorter and
// writes the returned median to the result RAM.
//
// Optional feature (compile-time macro MFE_BORDER_REPLICATE_EN):
//   undefined : out-of-image slots read as 0 and leave iaddr unchanged.
//   defined   : out-of-image rows/columns are clamped to the image edge, so
//               border windows replicate edge pixels.
//
// Window byte k = win_data[8k+7:8k], k = 3*r + c, r0 = row y-1, c0 = col x-1.
module mfe_window_sched #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    output logic                busy,
    output logic [AW-1:0]       iaddr,
    input  logic [7:0]          idata,
    mfe_window_sched_if.master  sorter,
    output logic [AW-1:0]       addr,
    output logic [7:0]          data_wr,
    output logic                wen
);

`ifdef MFE_BORDER_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    localparam logic [AW-1:0] X_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] Y_LAST = AW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_MED,
        S_WRITE
    } state_t;

    // A slot issued in one cycle is captured from idata in the next; this
    // record carries where (and how) the returning byte lands.
    typedef struct packed {
        logic       en;     // a byte is due from the ROM this cycle
        logic       zero;   // slot was outside the image: store 0
        logic       dup;    // also store into column x-1 (edge replicate)
        logic [3:0] k;      // destination window byte index
    } cap_t;

    state_t        state_q,     state_d;
    logic          busy_q,      busy_d;
    logic [AW-1:0] x_q,         x_d;
    logic [AW-1:0] y_q,         y_d;
    logic [2:0]    slot_q,      slot_d;
    logic [AW-1:0] iaddr_q,     iaddr_d;
    cap_t          cap_q,       cap_d;
    logic          win_valid_q, win_valid_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [7:0]    data_wr_q,   data_wr_d;
    logic          wen_q,       wen_d;
    logic [7:0]    pix_q [9];
    logic [7:0]    pix_d [9];

    // Slot decode for the current FETCH cycle.
    logic          row_start;
    logic [2:0]    slot_last;
    logic          slot_issue;
    logic [1:0]    slot_r;
    logic [1:0]    slot_c;
    logic [3:0]    slot_k;
    int            slot_row;
    int            slot_col;
    int            row_cl;
    int            col_cl;
    logic          slot_oob;
    logic [AW-1:0] slot_addr;
    logic [7:0]    cap_byte;

    // Decode which window position the current FETCH slot targets and the
    // ROM address it maps to (clamped into the image).
    always_comb begin
        row_start  = (x_q == '0);
        slot_last  = row_start ? 3'd6 : 3'd3;
        slot_issue = (state_q == S_FETCH) && (slot_q < slot_last);
        if (row_start) begin
            // Column-major: slots 0..2 fill column x, slots 3..5 column x+1.
            slot_c = (slot_q < 3'd3) ? 2'd1 : 2'd2;
            slot_r = (slot_q < 3'd3) ? slot_q[1:0] : 2'(slot_q - 3'd3);
        end else begin
            slot_c = 2'd2;
            slot_r = slot_q[1:0];
        end
        slot_k   = 4'(slot_r) * 4'd3 + 4'(slot_c);
        slot_row = int'(y_q) + int'(slot_r) - 1;
        slot_col = int'(x_q) + int'(slot_c) - 1;
        slot_oob = (slot_row < 0) || (slot_row >= IMG_H) || (slot_col >= IMG_W);
        row_cl   = (slot_row < 0) ? 0 : ((slot_row >= IMG_H) ? IMG_H - 1 : slot_row);
        col_cl   = (slot_col >= IMG_W) ? IMG_W - 1 : slot_col;
        slot_addr = AW'(row_cl * IMG_W + col_cl);
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        busy_d      = busy_q;
        x_d         = x_q;
        y_d         = y_q;
        slot_d      = slot_q;
        iaddr_d     = iaddr_q;
        cap_d       = '0;
        win_valid_d = win_valid_q;
        addr_d      = addr_q;
        data_wr_d   = data_wr_q;
        wen_d       = 1'b0;
        cap_byte    = 8'h00;
        for (int i = 0; i < 9; i++) begin
            pix_d[i] = pix_q[i];
        end

        unique case (state_q)
            S_IDLE: begin
                if (ready) begin
                    busy_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    slot_d  = 3'd0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // First FETCH cycle: no byte is in flight yet, so the column
                // buffers are free to shift (or, at row start, clear the
                // padding column x-1).
                if (slot_q == 3'd0) begin
                    for (int r = 0; r < 3; r++) begin
                        if (row_start) begin
                            pix_d[3*r] = 8'h00;
                        end else begin
                            pix_d[3*r]   = pix_q[3*r+1];
                            pix_d[3*r+1] = pix_q[3*r+2];
                        end
                    end
                end
                if (slot_issue) begin
                    // Out-of-image slots still take a cycle; in zero-pad mode
                    // iaddr keeps its last value and the byte is forced to 0.
                    if (REPLICATE || !slot_oob) begin
                        iaddr_d = slot_addr;
                    end
                    cap_d.en   = 1'b1;
                    cap_d.zero = !REPLICATE && slot_oob;
                    cap_d.dup  = REPLICATE && row_start && (slot_c == 2'd1);
                    cap_d.k    = slot_k;
                    slot_d     = slot_q + 3'd1;
                end else begin
                    // Final cycle only captures the last slot's byte.
                    slot_d      = 3'd0;
                    win_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (win_valid_q && sorter.win_ready) begin
                    win_valid_d = 1'b0;
                    state_d     = S_WAIT_MED;
                end
            end

            S_WAIT_MED: begin
                if (sorter.med_valid) begin
                    data_wr_d = sorter.med_data;
                    addr_d    = AW'(int'(y_q) * IMG_W + int'(x_q));
                    wen_d     = 1'b1;
                    state_d   = S_WRITE;
                end
            end

            S_WRITE: begin
                slot_d = 3'd0;
                if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                    x_d     = '0;
                    y_d     = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + AW'(1);
                    end else begin
                        x_d = x_q + AW'(1);
                    end
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Land the byte requested by last cycle's slot.
        if (cap_q.en) begin
            cap_byte       = cap_q.zero ? 8'h00 : idata;
            pix_d[cap_q.k] = cap_byte;
            if (cap_q.dup) begin
                pix_d[cap_q.k - 4'd1] = cap_byte;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            slot_q      <= 3'd0;
            iaddr_q     <= '0;
            cap_q       <= '0;
            win_valid_q <= 1'b0;
            addr_q      <= '0;
            data_wr_q   <= 8'h00;
            wen_q       <= 1'b0;
            // NOTE: the column buffers are reset because they drive win_data
            // directly, which must read 0 out of reset.
            for (int i = 0; i < 9; i++) begin
                pix_q[i] <= 8'h00;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            busy_q      <= busy_d;
            x_q         <= x_d;
            y_q         <= y_d;
            slot_q      <= slot_d;
            iaddr_q     <= iaddr_d;
            cap_q       <= cap_d;
            win_valid_q <= win_valid_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            wen_q       <= wen_d;
            for (int i = 0; i < 9; i++) begin
                pix_q[i] <= pix_d[i];
            end
        end
    end

    // iaddr is presented in the slot's own cycle so the ROM byte returns in
    // time for the next-cycle capture; iaddr_q remembers it for hold slots.
    assign iaddr            = iaddr_d;
    assign busy             = busy_q;
    assign addr             = addr_q;
    assign data_wr          = data_wr_q;
    assign wen              = wen_q;
    assign sorter.win_valid = win_valid_q;
    assign sorter.win_data  = {pix_q[8], pix_q[7], pix_q[6],
                               pix_q[5], pix_q[4], pix_q[3],
                               pix_q[2], pix_q[1], pix_q[0]};

endmodule

// File: tb/tb_mfe_window_sched.sv
// tb_mfe_window_sched: directed bench for mfe_window_sched on a 4x4 image.
// ROM model returns rom[iaddr] one cycle later; the sorter model echoes the
// window centre byte as the median.
module tb_mfe_window_sched;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int AW    = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          ready = 1'b0;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [7:0]    idata = 8'h00;
    logic [AW-1:0] addr;
    logic [7:0]    data_wr;
    logic          wen;

    mfe_window_sched_if sif ();

    mfe_window_sched #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ready   (ready),
        .busy    (busy),
        .iaddr   (iaddr),
        .idata   (idata),
        .sorter  (sif),
        .addr    (addr),
        .data_wr (data_wr),
        .wen     (wen)
    );

    always #5 clk = ~clk;

    // Synchronous input ROM.
    logic [7:0] rom [NPIX];
    always @(posedge clk) idata <= rom[iaddr];

    // Log every result-RAM write.
    int            wen_cnt = 0;
    logic [AW-1:0] wen_addr [64];
    logic [7:0]    wen_data [64];
    always @(negedge clk) begin
        if (wen) begin
            if (wen_cnt < 64) begin
                wen_addr[wen_cnt] = addr;
                wen_data[wen_cnt] = data_wr;
            end
            wen_cnt++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [71:0] exp_win;
        int          exp_fetch;
    } win_vec_t;

    win_vec_t      vecs [6];
    logic [AW-1:0] exp_trace [7];
    logic [71:0]   seen_win [NPIX];
    int            seen_fetch [NPIX];
    logic [AW-1:0] trace_iaddr [16];
    logic          trace_busy [16];

    // Serve one window: wait for it, optionally stall win_ready and the
    // median, then check the resulting write.
    task automatic serve_pixel(input int idx, input int hold, input int med_dly,
                               input logic [AW-1:0] exp_addr);
        int          n;
        logic [71:0] w;
        logic        bad;
        n = 0;
        do begin
            @(negedge clk);
            ready = 1'b0;
            n++;
            if (n < 16) begin
                trace_iaddr[n] = iaddr;
                trace_busy[n]  = busy;
            end
        end while (!sif.win_valid && n < 100);
        check("win_valid_timeout", 72'(sif.win_valid), 72'd1);
        if (!sif.win_valid) return;
        seen_fetch[idx] = n - 1;
        w = sif.win_data;
        seen_win[idx] = w;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", 72'(sif.win_valid), 72'd1);
            check("bp_data", sif.win_data, w);
        end
        sif.win_ready = 1'b1;
        @(negedge clk);
        sif.win_ready = 1'b0;
        check("valid_drop", 72'(sif.win_valid), 72'd0);
        bad = 1'b0;
        for (int i = 0; i < med_dly; i++) begin
            @(negedge clk);
            if (wen || sif.win_valid) bad = 1'b1;
        end
        if (med_dly > 0) check("quiet_wait_med", 72'(bad), 72'd0);
        sif.med_valid = 1'b1;
        sif.med_data  = w[39:32];
        @(negedge clk);
        sif.med_valid = 1'b0;
        check("wen_pulse", 72'(wen), 72'd1);
        check("wen_addr", 72'(addr), 72'(exp_addr));
        check("wen_data", 72'(data_wr), 72'(w[39:32]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      72'(busy),          72'd0);
        check({tag, "_iaddr"},     72'(iaddr),         72'd0);
        check({tag, "_win_valid"}, 72'(sif.win_valid), 72'd0);
        check({tag, "_win_data"},  sif.win_data,       72'd0);
        check({tag, "_addr"},      72'(addr),          72'd0);
        check({tag, "_data_wr"},   72'(data_wr),       72'd0);
        check({tag, "_wen"},       72'(wen),           72'd0);
    endtask

    initial begin
        int base;
        int abort_cnt;

        // Hand-computed windows on the address-pattern image (pixel = addr).
`ifdef MFE_BORDER_REPLICATE_EN
        vecs[0] = '{0,  72'h050404010000010000, 7};
        vecs[1] = '{3,  72'h070706030302030302, 4};
        vecs[2] = '{5,  72'h0A0908060504020100, 4};
        vecs[3] = '{6,  72'h0B0A09070605030201, 4};
        vecs[4] = '{8,  72'h0D0C0C090808050404, 7};
        vecs[5] = '{15, 72'h0F0F0E0F0F0E0B0B0A, 4};
        exp_trace = '{4'd0, 4'd0, 4'd4, 4'd1, 4'd1, 4'd5, 4'd5};
`else
        vecs[0] = '{0,  72'h050400010000000000, 7};
        vecs[1] = '{3,  72'h000706000302000000, 4};
        vecs[2] = '{5,  72'h0A0908060504020100, 4};
        vecs[3] = '{6,  72'h0B0A09070605030201, 4};
        vecs[4] = '{8,  72'h0D0C00090800050400, 7};
        vecs[5] = '{15, 72'h000000000F0E000B0A, 4};
        exp_trace = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd1, 4'd5, 4'd5};
`endif

        sif.win_ready = 1'b0;
        sif.med_valid = 1'b0;
        sif.med_data  = 8'h00;
        for (int i = 0; i < NPIX; i++) rom[i] = 8'(i);

        // Reset values.
        #1 reset = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: address-pattern image, full frame with backpressure.
        base  = wen_cnt;
        ready = 1'b1;
        for (int p = 0; p < NPIX; p++) begin
            serve_pixel(p, (p == 5) ? 5 : ((p == 2) ? 1 : 0),
                        (p == 5) ? 10 : ((p == 2) ? 3 : 0), AW'(p));
            if (p == 0) begin
                check("start_busy", 72'(trace_busy[1]), 72'd1);
                for (int k = 0; k < 7; k++) begin
                    check($sformatf("first_iaddr_%0d", k), 72'(trace_iaddr[k+1]), 72'(exp_trace[k]));
                end
            end
        end
        @(negedge clk);
        check("end_busy", 72'(busy), 72'd0);
        check("end_wen", 72'(wen), 72'd0);
        #1;
        check("frame_wen_count", 72'(wen_cnt - base), 72'(NPIX));
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("log_addr_%0d", i), 72'(wen_addr[base+i]), 72'(i));
            check($sformatf("log_data_%0d", i), 72'(wen_data[base+i]), 72'(i));
        end
        for (int v = 0; v < 6; v++) begin
            check($sformatf("win_%0d", vecs[v].idx), seen_win[vecs[v].idx], vecs[v].exp_win);
            check($sformatf("fetch_%0d", vecs[v].idx), 72'(seen_fetch[vecs[v].idx]), 72'(vecs[v].exp_fetch));
        end

        // Frame 2: constant 0x55 image, aborted by reset after the 6th write.
        for (int i = 0; i < NPIX; i++) rom[i] = 8'h55;
        ready = 1'b1;
        for (int p = 0; p < 6; p++) serve_pixel(p, 0, 0, AW'(p));
`ifdef MFE_BORDER_REPLICATE_EN
        check("const_win_0_0", seen_win[0], 72'h555555555555555555);
`else
        check("const_win_0_0", seen_win[0], 72'h555500555500000000);
`endif
        check("const_win_1_1", seen_win[5], 72'h555555555555555555);
        check("const_data_wr", 72'(data_wr), 72'h55);
        #2 reset = 1'b1;
        #1 check_outputs_zero("abort");
        abort_cnt = wen_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_wen_after_abort", 72'(wen_cnt - abort_cnt), 72'd0);

        // Frame 3: restart after abort begins again at (0,0).
        for (int i = 0; i < NPIX; i++) rom[i] = 8'(i);
        base  = wen_cnt;
        ready = 1'b1;
        serve_pixel(0, 0, 0, AW'(0));
        check("restart_win", seen_win[0], vecs[0].exp_win);
        #1;
        check("restart_log_addr", 72'(wen_addr[base]), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
